r2_seq_divider: RTL and testbench

Iterative radix-2 restoring signed divider. It is the inverse-operation companion to the team's iterative Booth multiplier and uses the same Ld/Valid start-and-done handshake, so both units slot into the approximate-FFT datapath interchangeably. One quotient bit is produced per cycle on operand magnitudes. A single sign-fixup cycle then produces a two's-complement quotient and remainder.

---
 rtl/r2_div_pkg.sv | 11 +
 rtl/r2_div_step.sv | 25 ++
 rtl/r2_seq_divider.sv | 127 ++++++++++++
 tb/tb_r2_seq_divider.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/r2_div_pkg.sv
// Shared definitions for the radix-2 restoring divider.
//   state_t   : FSM encoding (IDLE/CALC/FIX)
//   CNT_W     : iteration counter width, sized for the largest legal N (32)
//   DIVZERO_Q : quotient presented for a zero divisor (all ones, sliced to N)
package r2_div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam int DIV_N_MAX = 32;
  localparam int CNT_W     = $clog2(DIV_N_MAX + 1);
  localparam logic [DIV_N_MAX-1:0] DIVZERO_Q = '1;
endpackage

// File: rtl/r2_div_step.sv
// One restoring-division iteration (combinational).
//   pr     : partial remainder (N+1 bits)
//   a_msb  : next dividend-magnitude bit shifted into PR
//   dv     : divisor magnitude
//   pr_nxt : partial remainder after trial subtract / restore
//   qbit   : quotient bit (1 when the trial difference is non-negative)
module r2_div_step #(
  parameter int N = 16
) (
  input  logic [N:0]   pr,
  input  logic         a_msb,
  input  logic [N-1:0] dv,
  output logic [N:0]   pr_nxt,
  output logic         qbit
);
  // One extra bit on top so the borrow shows up as the sign.
  logic [N+1:0] sh;
  logic [N+1:0] diff;

  assign sh     = {pr, a_msb};
  assign diff   = sh - {2'b00, dv};
  assign qbit   = ~diff[N+1];
  // PR < |V| always holds, so both candidates fit in N+1 bits.
  assign pr_nxt = qbit ? diff[N:0] : sh[N:0];
endmodule

// File: rtl/r2_seq_divider.sv
// Iterative radix-2 restoring signed divider, one quotient bit per cycle on
// operand magnitudes followed by one sign-fixup cycle.
// Ports:
//   Clk, Rst (sync, active-high)
//   Ld      : load D/V and start; restarts from any state
//   D, V    : dividend / divisor, signed
//   Busy    : division in progress
//   Valid   : one-cycle result strobe
//   Q, Rm   : quotient (toward zero) / remainder (sign of dividend)
//   DivZero : divisor was zero for the presented result
// Optional: define APPROX_DIV_EN to stop after N-K iterations, zero the low
// K quotient bits and force Rm to 0.
module r2_seq_divider
  import r2_div_pkg::*;
#(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Ld,
  input  logic [N-1:0] D,
  input  logic [N-1:0] V,
  output logic         Busy,
  output logic         Valid,
  output logic [N-1:0] Q,
  output logic [N-1:0] Rm,
  output logic         DivZero
);
`ifdef APPROX_DIV_EN
  localparam bit APPROX = 1'b1;
`else
  localparam bit APPROX = 1'b0;
`endif
  localparam int ITERS = APPROX ? N - K : N;
  localparam int QSH   = APPROX ? K : 0;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [N:0]       pr;
  logic [N-1:0]     a;     // dividend magnitude, quotient bits shift in at LSB
  logic [N-1:0]     dv;
  logic             sd, sq, zf;

  logic [N:0]       pr_nxt;
  logic             qb;
  logic [N-1:0]     qmag, rmag;

  r2_div_step #(.N(N)) u_step (
    .pr     (pr),
    .a_msb  (a[N-1]),
    .dv     (dv),
    .pr_nxt (pr_nxt),
    .qbit   (qb)
  );

  // In approximate mode only the top N-K quotient bits were produced; they
  // sit in the low bits of a and move up into place with zeros below.
  assign qmag = a << QSH;
  assign rmag = APPROX ? '0 : pr[N-1:0];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pr      <= '0;
      a       <= '0;
      dv      <= '0;
      sd      <= 1'b0;
      sq      <= 1'b0;
      zf      <= 1'b0;
      Busy    <= 1'b0;
      Valid   <= 1'b0;
      Q       <= '0;
      Rm      <= '0;
      DivZero <= 1'b0;
    end else begin
      Valid <= 1'b0;
      if (Ld) begin
        a    <= D[N-1] ? -D : D;
        dv   <= V[N-1] ? -V : V;
        sd   <= D[N-1];
        sq   <= D[N-1] ^ V[N-1];
        pr   <= '0;
        Busy <= 1'b1;
        if (V == '0) begin
          // Zero divisor waits one cycle in FIX so its result lands two
          // cycles after Ld.
          zf    <= 1'b1;
          cnt   <= CNT_W'(1);
          state <= FIX;
        end else begin
          zf    <= 1'b0;
          cnt   <= CNT_W'(ITERS);
          state <= CALC;
        end
      end else begin
        case (state)
          CALC: begin
            pr  <= pr_nxt;
            a   <= {a[N-2:0], qb};
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= FIX;
          end
          FIX: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else begin
              if (zf) begin
                Q  <= DIVZERO_Q[N-1:0];
                Rm <= sd ? -a : a;   // reconstructs D as captured
              end else begin
                Q  <= sq ? -qmag : qmag;
                Rm <= sd ? -rmag : rmag;
              end
              DivZero <= zf;
              Valid   <= 1'b1;
              Busy    <= 1'b0;
              state   <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_r2_seq_divider.sv
// Self-checking bench for r2_seq_divider: directed corner cases, sequencing,
// reset and randomized operands against an arithmetic reference model.
module tb_r2_seq_divider;
  localparam int N = 16;
  localparam int K = 4;

  logic         Clk = 1'b0;
  logic         Rst, Ld, Busy, Valid, DivZero;
  logic [N-1:0] D, V, Q, Rm;

  int nchk = 0;
  int nerr = 0;

  r2_seq_divider #(.N(N), .K(K)) dut (
    .Clk(Clk), .Rst(Rst), .Ld(Ld), .D(D), .V(V), .Busy(Busy),
    .Valid(Valid), .Q(Q), .Rm(Rm), .DivZero(DivZero)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed arithmetic on the operand values.
  task automatic ref_div(input logic [N-1:0] d, input logic [N-1:0] v,
                         output logic [N-1:0] q, output logic [N-1:0] r,
                         output logic z, output int lat);
    int di, vi, qi, ri, qm;
    di = int'($signed(d));
    vi = int'($signed(v));
    if (vi == 0) begin
      q = '1; r = d; z = 1'b1; lat = 2;
    end else begin
      qi = di / vi;
      ri = di % vi;
      z  = 1'b0;
`ifdef APPROX_DIV_EN
      qm  = (qi < 0 ? -qi : qi) & ~((1 << K) - 1);
      qi  = (qi < 0) ? -qm : qm;
      ri  = 0;
      lat = N - K + 1;
`else
      qm  = 0;
      lat = N + 1;
`endif
      q = qi[N-1:0];
      r = ri[N-1:0];
    end
  endtask

  // Inputs change #1 after a rising edge; Ld is sampled on the next edge.
  task automatic start(input logic [N-1:0] d, input logic [N-1:0] v);
    D = d; V = v; Ld = 1'b1;
    @(posedge Clk); #1;
    Ld = 1'b0;
  endtask

  task automatic div_chk(input string tag, input logic [N-1:0] d, input logic [N-1:0] v);
    logic [N-1:0] eq, er;
    logic         ez;
    int           elat, e, nbusy;
    ref_div(d, v, eq, er, ez, elat);
    start(d, v);
    e = 0; nbusy = 0;
    while (!Valid && e < 100) begin
      if (Busy) nbusy++;
      @(posedge Clk); #1;
      e++;
    end
    chk({tag, ".valid"}, Valid, 1);
    chk({tag, ".lat"}, e, elat);
    chk({tag, ".busy"}, nbusy, elat);
    chk({tag, ".q"}, Q, eq);
    chk({tag, ".rm"}, Rm, er);
    chk({tag, ".dz"}, DivZero, ez);
  endtask

  initial begin
    logic [N-1:0] hq, hr, rd, rv;
    int nv;
    Rst = 1'b1; Ld = 1'b0; D = '0; V = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst.busy", Busy, 0);
    chk("rst.valid", Valid, 0);
    chk("rst.q", Q, 0);
    chk("rst.rm", Rm, 0);
    chk("rst.dz", DivZero, 0);
    Rst = 1'b0;

    div_chk("p100_7", 16'd100, 16'd7);
    div_chk("n100_7", 16'hFF9C, 16'd7);
    div_chk("p100_n7", 16'd100, 16'hFFF9);
    div_chk("ovf", 16'h8000, 16'hFFFF);
    div_chk("max_1", 16'h7FFF, 16'd1);
    div_chk("dz", 16'd1234, 16'd0);
    div_chk("after_dz", 16'd100, 16'd7);

    // Outputs hold between Valid pulses.
    hq = Q; hr = Rm;
    repeat (5) @(posedge Clk);
    #1;
    chk("hold.q", Q, hq);
    chk("hold.rm", Rm, hr);
    chk("hold.valid", Valid, 0);

    // Restart mid-CALC: only the second op completes, full latency.
    start(16'd100, 16'd7);
    repeat (5) @(posedge Clk);
    #1;
    div_chk("abort", 16'd50, 16'd5);

    // Reset mid-CALC: outputs cleared, no Valid afterwards.
    start(16'd100, 16'd7);
    repeat (4) @(posedge Clk);
    #1;
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    chk("mrst.q", Q, 0);
    chk("mrst.rm", Rm, 0);
    chk("mrst.busy", Busy, 0);
    nv = 0;
    repeat (25) begin
      if (Valid) nv++;
      @(posedge Clk); #1;
    end
    chk("mrst.novalid", nv, 0);

    // Randomized operands, with extra weight on zero/extreme divisors.
    for (int i = 0; i < 40; i++) begin
      rd = N'($urandom);
      case ($urandom_range(0, 7))
        0:       rv = '0;
        1:       rv = 16'hFFFF;
        2:       rv = 16'h8000;
        3:       rv = N'($urandom_range(1, 15));
        default: rv = N'($urandom);
      endcase
      if ($urandom_range(0, 9) == 0) rd = 16'h8000;
      div_chk($sformatf("rnd%0d", i), rd, rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
